// File: rtl/shift_add_multiplier_pkg.sv
// Shared constants and FSM encoding for the shift-and-add multiplier.
package shift_add_multiplier_pkg;

    localparam int unsigned C_NUM_BITS_DEF = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        CPLT = 2'd2
    } state_e;

    // Step counter must be able to hold N.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    localparam int unsigned CNT_W = cnt_width(C_NUM_BITS_DEF);

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Operand/result bus between a requester and the multiplier.
interface shift_add_multiplier_if
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned C_NUM_BITS = C_NUM_BITS_DEF
);
    logic                      E;
    logic                      START;
    logic [C_NUM_BITS-1:0]     A;
    logic [C_NUM_BITS-1:0]     B;
    logic [2*C_NUM_BITS-1:0]   P;
    logic                      BUSY;
    logic                      DONE;

    modport master (output E, START, A, B, input P, BUSY, DONE);
    modport slave  (input E, START, A, B, output P, BUSY, DONE);
endinterface

// File: rtl/shift_add_multiplier_mul_step.sv
// One add-and-shift step: conditional (N+1)-bit add into the high half, then
// shift {carry, high, low} right by one.
module mul_step
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned C_NUM_BITS = C_NUM_BITS_DEF
) (
    input  logic [C_NUM_BITS-1:0] mcand,
    input  logic [C_NUM_BITS-1:0] hi,
    input  logic [C_NUM_BITS-1:0] lo,
    output logic [C_NUM_BITS-1:0] hi_c,
    output logic [C_NUM_BITS-1:0] lo_c
);
    logic [C_NUM_BITS:0]   sum_c;
    logic [C_NUM_BITS-1:0] addend_c;

    assign addend_c = lo[0] ? mcand : '0;
    // The carry out lives in sum_c[N] and is shifted straight into the high half.
    assign sum_c    = {1'b0, hi} + {1'b0, addend_c};
    assign hi_c     = sum_c[C_NUM_BITS:1];
    assign lo_c     = {sum_c[0], lo[C_NUM_BITS-1:1]};
endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per enabled clock,
// N steps per product.
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int unsigned C_NUM_BITS = C_NUM_BITS_DEF
) (
    input  logic                 CK,
    input  logic                 R,
    shift_add_multiplier_if.slave bus
);
    localparam int unsigned N  = C_NUM_BITS;
    localparam int unsigned CW = cnt_width(C_NUM_BITS);

    state_e          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [N-1:0]    mcand, mcand_n;
    logic [N-1:0]    hi, hi_n;
    logic [N-1:0]    lo, lo_n;
    logic [2*N-1:0]  p, p_n;
    logic            busy, busy_n;
    logic            done, done_n;
    logic [N-1:0]    step_hi_c, step_lo_c;

    mul_step #(.C_NUM_BITS(N)) u_step (
        .mcand (mcand),
        .hi    (hi),
        .lo    (lo),
        .hi_c  (step_hi_c),
        .lo_c  (step_lo_c)
    );

    // State and datapath registers.
    always_ff @(posedge CK or posedge R) begin
        if (R) begin
            state <= IDLE;
            cnt   <= '0;
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
            p     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            mcand <= mcand_n;
            hi    <= hi_n;
            lo    <= lo_n;
            p     <= p_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Next-state, datapath and flag logic; everything holds while E is low.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mcand_n = mcand;
        hi_n    = hi;
        lo_n    = lo;
        p_n     = p;

        if (bus.E) begin
            unique case (state)
                IDLE, CPLT: begin
                    if (bus.START) begin
                        mcand_n = bus.A;
                        lo_n    = bus.B;
                        hi_n    = '0;
                        cnt_n   = '0;
                        state_n = RUN;
                    end
                end
                RUN: begin
                    hi_n  = step_hi_c;
                    lo_n  = step_lo_c;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        p_n     = {step_hi_c, step_lo_c};
                        state_n = CPLT;
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // Flags track the state they will accompany, so they stay registered.
        busy_n = (state_n == RUN);
        done_n = (state_n == CPLT);
    end

    assign bus.P    = p;
    assign bus.BUSY = busy;
    assign bus.DONE = done;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier with hand-computed products.
module tb_shift_add_multiplier;
    localparam int unsigned N = 24;

    logic CK;
    logic R;
    int   checks;
    int   errors;

    shift_add_multiplier_if #(.C_NUM_BITS(N)) bus ();

    shift_add_multiplier #(.C_NUM_BITS(N)) dut (
        .CK  (CK),
        .R   (R),
        .bus (bus)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CK);
            #1;
        end
    endtask

    // Present operands with START for exactly one edge (counts as edge 1).
    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b);
        bus.A     = a;
        bus.B     = b;
        bus.START = 1'b1;
        step(1);
        bus.START = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        R         = 1'b1;
        bus.E     = 1'b1;
        bus.START = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        step(2);
        chk("reset_p", 64'(bus.P), 64'h0);
        chk("reset_busy", 64'(bus.BUSY), 64'h0);
        chk("reset_done", 64'(bus.DONE), 64'h0);
        R = 1'b0;

        // 3*5, started on the first edge after reset release.
        start_op(24'd3, 24'd5);
        chk("3x5_busy_start", 64'({bus.BUSY, bus.DONE}), 64'h2);
        step(23);
        chk("3x5_busy_edge24", 64'({bus.BUSY, bus.DONE}), 64'h2);
        chk("3x5_p_held", 64'(bus.P), 64'h0);
        step(1);
        chk("3x5_done_edge25", 64'({bus.BUSY, bus.DONE}), 64'h1);
        chk("3x5_p", 64'(bus.P), 64'h00000000000F);

        // Max operands straight from CPLT; exercises the carry path.
        start_op(24'hFFFFFF, 24'hFFFFFF);
        chk("max_done_cleared", 64'({bus.BUSY, bus.DONE}), 64'h2);
        chk("max_p_held_run", 64'(bus.P), 64'h00000000000F);
        step(24);
        chk("max_done", 64'(bus.DONE), 64'h1);
        chk("max_p", 64'(bus.P), 64'hFFFFFE000001);

        // Zero multiplicand keeps the same latency.
        start_op(24'h000000, 24'hABCDEF);
        step(23);
        chk("zero_not_done_early", 64'(bus.DONE), 64'h0);
        step(1);
        chk("zero_done", 64'(bus.DONE), 64'h1);
        chk("zero_p", 64'(bus.P), 64'h0);

        // START during RUN is ignored; later operand changes have no effect.
        start_op(24'h000100, 24'h000200);
        step(9);
        bus.A     = 24'hFFFFFF;
        bus.B     = 24'hFFFFFF;
        bus.START = 1'b1;
        step(1);
        bus.START = 1'b0;
        bus.A     = 24'h5A5A5A;
        bus.B     = 24'hA5A5A5;
        step(13);
        chk("ignore_busy_edge24", 64'({bus.BUSY, bus.DONE}), 64'h2);
        step(1);
        chk("ignore_done", 64'(bus.DONE), 64'h1);
        chk("ignore_p", 64'(bus.P), 64'h000000020000);

        // Five stalled cycles mid-run extend latency to 30 edges.
        start_op(24'd7, 24'd9);
        step(5);
        bus.E = 1'b0;
        step(5);
        chk("stall_busy_frozen", 64'({bus.BUSY, bus.DONE}), 64'h2);
        chk("stall_p_frozen", 64'(bus.P), 64'h000000020000);
        bus.E = 1'b1;
        step(18);
        chk("stall_not_done_edge29", 64'({bus.BUSY, bus.DONE}), 64'h2);
        step(1);
        chk("stall_done_edge30", 64'(bus.DONE), 64'h1);
        chk("stall_p", 64'(bus.P), 64'h3F);

        // Asynchronous reset mid-run aborts without a later DONE.
        start_op(24'h123456, 24'h000010);
        step(11);
        #2 R = 1'b1;
        #1;
        chk("abort_p_async", 64'(bus.P), 64'h0);
        chk("abort_flags_async", 64'({bus.BUSY, bus.DONE}), 64'h0);
        step(1);
        R = 1'b0;
        step(30);
        chk("abort_no_done", 64'({bus.BUSY, bus.DONE}), 64'h0);
        chk("abort_p_stays", 64'(bus.P), 64'h0);

        // Back-to-back: 4*4 then 2*3 issued in CPLT.
        start_op(24'd4, 24'd4);
        step(24);
        chk("b2b_first_done", 64'(bus.DONE), 64'h1);
        chk("b2b_first_p", 64'(bus.P), 64'h10);
        start_op(24'd2, 24'd3);
        chk("b2b_done_cleared", 64'({bus.BUSY, bus.DONE}), 64'h2);
        step(23);
        chk("b2b_done_low", 64'(bus.DONE), 64'h0);
        chk("b2b_p_held", 64'(bus.P), 64'h10);
        step(1);
        chk("b2b_done", 64'({bus.BUSY, bus.DONE}), 64'h1);
        chk("b2b_p", 64'(bus.P), 64'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
